reed_solomon_decoder_pack_fifo: RTL and testbench

//   Byte-to-line packing FIFO on the decoder output path. Takes corrected bytes
//   one per cycle and packs them into 64-byte (512-bit) lines for line-wide writeback.
//   It is the mirror of the line-to-byte input FIFO. A flush closes a partial line.

---
 rtl/reed_solomon_decoder_pkg.sv | 14 +
 rtl/reed_solomon_decoder_line_assembler.sv | 54 +++++
 rtl/reed_solomon_decoder_pack_fifo.sv | 84 ++++++++
 tb/tb_reed_solomon_decoder_pack_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reed_solomon_decoder_pkg.sv
// Shared types for the Reed-Solomon decoder output path: line geometry and
// per-line metadata carried alongside each packed 512-bit line.
package reed_solomon_decoder_pkg;
  localparam int RS_LINE_BYTES = 64;
  localparam int RS_LINE_BITS  = 512;
  localparam int RS_OFF_W      = 6;

  typedef logic [RS_LINE_BITS-1:0] rs_line_t;

  typedef struct packed {
    logic [6:0] valid_bytes;
    logic       last;
  } rs_line_meta_t;
endpackage

// File: rtl/reed_solomon_decoder_line_assembler.sv
// Collects accepted bytes into the partial line and raises commit when the
// line fills or a flush closes it; the committed image includes this cycle's byte.
module reed_solomon_decoder_line_assembler
  import reed_solomon_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          enq_data,
  input  logic                enq_en,
  input  logic                flush,
  input  logic                not_full,
  output logic                commit,
  output rs_line_t            line,
  output rs_line_meta_t       meta,
  output logic [RS_OFF_W-1:0] wr_off
);
  logic                           accept;
  logic [RS_LINE_BYTES-1:0][7:0]  line_q, line_n;

  assign accept = enq_en && not_full;

  for (genvar k = 0; k < RS_LINE_BYTES; k++) begin : g_lane
    assign line_n[k] = (accept && wr_off == RS_OFF_W'(k)) ? enq_data : line_q[k];
  end

  assign line = line_n;

  always_comb begin
    commit           = 1'b0;
    meta.valid_bytes = '0;
    meta.last        = flush;
    if (accept) begin
      commit           = (wr_off == RS_OFF_W'(RS_LINE_BYTES - 1)) || flush;
      meta.valid_bytes = {1'b0, wr_off} + 7'd1;
    end else if (flush && wr_off != '0) begin
      commit           = 1'b1;
      meta.valid_bytes = {1'b0, wr_off};
    end
  end

  // Clearing on commit zero-fills the next slot so short lines pad with zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_off <= '0;
      line_q <= '0;
    end else if (commit) begin
      wr_off <= '0;
      line_q <= '0;
    end else if (accept) begin
      wr_off <= wr_off + RS_OFF_W'(1);
      line_q <= line_n;
    end
  end
endmodule

// File: rtl/reed_solomon_decoder_pack_fifo.sv
// Byte-to-line packing FIFO: assembler builds lines, this level stores committed
// lines with metadata and presents the head line fall-through.
module reed_solomon_decoder_pack_fifo
  import reed_solomon_decoder_pkg::*;
#(
  parameter  int DEPTH_BYTES = 512,
  localparam int LINES       = DEPTH_BYTES / RS_LINE_BYTES,
  localparam int PW          = $clog2(LINES),
  localparam int CW          = PW + 1,
  localparam int BW          = $clog2(DEPTH_BYTES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        enq_data,
  input  logic              enq_en,
  input  logic              flush,
  output logic              not_full,
  output logic [511:0]      deq_data,
  output logic [6:0]        deq_valid_bytes,
  output logic              deq_last,
  input  logic              deq_en,
  output logic              not_empty,
  output logic [CW-1:0]     line_count,
  output logic [BW-1:0]     byte_count
);
  rs_line_t            line_mem [LINES];
  rs_line_meta_t       meta_mem [LINES];
  logic [PW-1:0]       wr_line, rd_line;
  logic                commit, pop;
  rs_line_t            asm_line;
  rs_line_meta_t       asm_meta;
  logic [RS_OFF_W-1:0] wr_off;

  assign not_full  = (line_count != CW'(LINES));
  assign not_empty = (line_count != '0);
  assign pop       = deq_en && not_empty;

  reed_solomon_decoder_line_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .enq_data (enq_data),
    .enq_en   (enq_en),
    .flush    (flush),
    .not_full (not_full),
    .commit   (commit),
    .line     (asm_line),
    .meta     (asm_meta),
    .wr_off   (wr_off)
  );

  // A commit can only occur while not full (wr_off stays 0 when full), so wr_line never hits a live slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        line_mem[i] <= '0;
        meta_mem[i] <= '0;
      end
    end else if (commit) begin
      line_mem[wr_line] <= asm_line;
      meta_mem[wr_line] <= asm_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_line    <= '0;
      rd_line    <= '0;
      line_count <= '0;
    end else begin
      if (commit) wr_line <= wr_line + PW'(1);
      if (pop)    rd_line <= rd_line + PW'(1);
      case ({commit, pop})
        2'b10:   line_count <= line_count + CW'(1);
        2'b01:   line_count <= line_count - CW'(1);
        default: line_count <= line_count;
      endcase
    end
  end

  assign deq_data        = not_empty ? line_mem[rd_line] : '0;
  assign deq_valid_bytes = not_empty ? meta_mem[rd_line].valid_bytes : '0;
  assign deq_last        = not_empty ? meta_mem[rd_line].last : 1'b0;
  assign byte_count      = {line_count, wr_off};
endmodule

// File: tb/tb_reed_solomon_decoder_pack_fifo.sv
// Bench for the byte-to-line packing FIFO: queue-based reference model checked
// every cycle, a table of line-closing vectors, and directed corner sequences.
module tb_reed_solomon_decoder_pack_fifo;
  import reed_solomon_decoder_pkg::*;
  localparam int LINES = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic [7:0]   enq_data = '0;
  logic         enq_en = 1'b0, flush = 1'b0, deq_en = 1'b0;
  logic         not_full, not_empty, deq_last;
  logic [511:0] deq_data;
  logic [6:0]   deq_valid_bytes;
  logic [3:0]   line_count;
  logic [9:0]   byte_count;

  reed_solomon_decoder_pack_fifo #(.DEPTH_BYTES(512)) dut (
    .clk(clk), .reset(reset), .enq_data(enq_data), .enq_en(enq_en), .flush(flush),
    .not_full(not_full), .deq_data(deq_data), .deq_valid_bytes(deq_valid_bytes),
    .deq_last(deq_last), .deq_en(deq_en), .not_empty(not_empty),
    .line_count(line_count), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {logic [511:0] data; int vb; bit last;} mline_t;
  mline_t     mq[$];
  logic [7:0] pq[$];

  typedef struct {int n; logic [7:0] base; int fmode; int evb; bit elast; logic [7:0] eb0; logic [7:0] eb63;} vec_t;
  vec_t vt[6];

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(bit en, logic [7:0] d, bit fl, bit de);
    bit     full, pop, cm;
    mline_t ml;
    full = (mq.size() == LINES);
    pop  = de && (mq.size() > 0);
    cm   = 1'b0;
    ml.data = '0; ml.vb = 0; ml.last = 1'b0;
    if (en && !full) pq.push_back(d);
    if (pq.size() == 64 || (fl && pq.size() > 0)) begin
      foreach (pq[i]) ml.data[8*i +: 8] = pq[i];
      ml.vb = pq.size(); ml.last = fl; cm = 1'b1;
      pq.delete();
    end
    if (pop) void'(mq.pop_front());
    if (cm) mq.push_back(ml);
  endtask

  task automatic chk_state();
    chk("not_full",   not_full,   mq.size() != LINES);
    chk("not_empty",  not_empty,  mq.size() != 0);
    chk("line_count", line_count, mq.size());
    chk("byte_count", byte_count, mq.size() * 64 + pq.size());
    if (mq.size() > 0) begin
      chk("deq_data", deq_data, mq[0].data);
      chk("deq_vb",   deq_valid_bytes, mq[0].vb);
      chk("deq_last", deq_last, mq[0].last);
    end else begin
      chk("deq_data_empty", deq_data, 0);
      chk("deq_vb_empty",   deq_valid_bytes, 0);
      chk("deq_last_empty", deq_last, 0);
    end
  endtask

  task automatic cyc(bit en, logic [7:0] d, bit fl, bit de);
    enq_en = en; enq_data = d; flush = fl; deq_en = de;
    @(posedge clk);
    model_step(en, d, fl, de);
    #1;
    chk_state();
    enq_en = 1'b0; flush = 1'b0; deq_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    mq.delete(); pq.delete();
    chk_state();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vt[0] = '{64, 8'h00, 0, 64, 1'b0, 8'h00, 8'h3F};
    vt[1] = '{5,  8'hAA, 2, 5,  1'b1, 8'hAA, 8'h00};
    vt[2] = '{6,  8'hAA, 1, 6,  1'b1, 8'hAA, 8'h00};
    vt[3] = '{64, 8'h10, 1, 64, 1'b1, 8'h10, 8'h4F};
    vt[4] = '{1,  8'h77, 1, 1,  1'b1, 8'h77, 8'h00};
    vt[5] = '{63, 8'h80, 2, 63, 1'b1, 8'h80, 8'h00};

    #12;
    do_reset();
    chk("rst_nf", not_full, 1);
    chk("rst_bc", byte_count, 0);

    // Flush with nothing pending is a no-op.
    cyc(0, 8'h00, 1, 0);
    chk("flush_noop_lc", line_count, 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].n; i++)
        cyc(1, 8'(vt[v].base + 8'(i)), (vt[v].fmode == 1) && (i == vt[v].n - 1), 0);
      if (vt[v].fmode == 2) cyc(0, 8'h00, 1, 0);
      chk("vec_ne",   not_empty, 1);
      chk("vec_vb",   deq_valid_bytes, vt[v].evb);
      chk("vec_last", deq_last, vt[v].elast);
      chk("vec_b0",   deq_data[7:0], vt[v].eb0);
      chk("vec_b63",  deq_data[511:504], vt[v].eb63);
      chk("vec_pad",  deq_data >> (8 * vt[v].evb), 0);
      cyc(0, 8'h00, 0, 1);
    end
    cyc(0, 8'h00, 0, 1);  // pop while empty is ignored

    // Fill to capacity, drop when full, pop while full.
    do_reset();
    for (int i = 0; i < 512; i++) cyc(1, 8'(i), 0, 0);
    chk("full_nf", not_full, 0);
    cyc(1, 8'hEE, 0, 0);
    chk("drop_bc", byte_count, 512);
    cyc(1, 8'hEF, 0, 1);
    chk("pop_nf", not_full, 1);
    chk("pop_bc", byte_count, 448);
    cyc(1, 8'h5A, 0, 0);
    chk("slot0_bc", byte_count, 449);
    chk("head1_b0", deq_data[7:0], 8'h40);
    chk("head1_b63", deq_data[511:504], 8'h7F);

    // Steady streaming through several pointer wraps.
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1, 8'(i * 3), 0, 0);
    for (int c = 0; c < 64 * 26; c++) begin
      cyc(1, 8'(c * 7 + 3), 0, (c % 64) == 63);
      if ((c % 64) == 63) chk("steady_lc", line_count, 4);
    end

    // Asynchronous reset mid-line leaves nothing behind.
    do_reset();
    for (int i = 0; i < 158; i++) cyc(1, 8'(i + 9), 0, 0);
    chk("pre_rst_bc", byte_count, 158);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_lc", line_count, 0);
    chk("arst_bc", byte_count, 0);
    chk("arst_ne", not_empty, 0);
    mq.delete(); pq.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) cyc(1, 8'(8'hC0 + 8'(i)), 0, 0);
    chk("clean_lc", line_count, 1);
    chk("clean_b0", deq_data[7:0], 8'hC0);
    chk("clean_b30", deq_data[247:240], 8'hDE);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++)
      cyc($urandom_range(0, 9) != 0, 8'($urandom), $urandom_range(0, 30) == 0,
          $urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
